// File: rtl/image_stream_pkg.sv
// Shared types and helpers for the image stream framer.
package image_stream_pkg;

  localparam int UF_W   = 16;
  localparam int MAP_W  = 1024;
  localparam int MAP_AW = 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NFP  = 3'd1,
    NFW  = 3'd2,
    GAP  = 3'd3,
    ROW  = 3'd4,
    FIN  = 3'd5
  } state_e;

  // Reorders lane_n lanes of dwidth bits; bits above lane_n*dwidth come back zero.
  function automatic logic [MAP_W-1:0] lane_map(input logic [MAP_W-1:0] data,
                                                input logic             reverse,
                                                input int               lane_n,
                                                input int               dwidth);
    logic [MAP_W-1:0] res;
    int               src;
    res = '0;
    for (int b = 0; b < MAP_W; b++) begin
      if (b < lane_n * dwidth) begin
        if (reverse) begin
          src = (lane_n - 1 - (b / dwidth)) * dwidth + (b % dwidth);
        end else begin
          src = b;
        end
        res[MAP_AW'(b)] = data[MAP_AW'(src)];
      end else begin
        res[MAP_AW'(b)] = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_beat_counter.sv
// Row and beat position tracker for the framer, with first/last flags.
module stream_beat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [CNT_W-1:0] row_size,
  input  logic [CNT_W-1:0] beats_per_row,
  output logic             first_beat,
  output logic             last_beat,
  output logic             last_row
);

  logic [CNT_W-1:0] beat_cnt_r;
  logic [CNT_W-1:0] row_cnt_r;

  // Beat counter wraps at end of row; the wrap advances the row counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      beat_cnt_r <= '0;
      row_cnt_r  <= '0;
    end else if (clr) begin
      beat_cnt_r <= '0;
      row_cnt_r  <= '0;
    end else if (adv && last_beat) begin
      beat_cnt_r <= '0;
      row_cnt_r  <= row_cnt_r + CNT_W'(1);
    end else if (adv) begin
      beat_cnt_r <= beat_cnt_r + CNT_W'(1);
    end else begin
      beat_cnt_r <= beat_cnt_r;
      row_cnt_r  <= row_cnt_r;
    end
  end

  assign first_beat = (beat_cnt_r == '0);
  assign last_beat  = (beat_cnt_r == beats_per_row - CNT_W'(1));
  assign last_row   = (row_cnt_r == row_size - CNT_W'(1));

endmodule

// File: rtl/image_stream_framer.sv
// Frame source: pulls multi-lane beats upstream and re-emits them as a
// row-structured stream with frame/row markers and inter-row gaps.
module image_stream_framer
  import image_stream_pkg::*;
#(
  parameter int DWIDTH        = 10,
  parameter int LANE_N        = 8,
  parameter int CNT_W         = 16,
  parameter int GAP_W         = 8,
  parameter int NF_GAP        = 4,
  parameter int REVERSE_LANES = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         rowSize,
  input  logic [CNT_W-1:0]         pixPerSlot,
  input  logic [GAP_W-1:0]         rowGap,
  input  logic [LANE_N*DWIDTH-1:0] s_data,
  input  logic                     s_vld,
  output logic                     s_rdy,
  output logic                     new_frame,
  output logic [LANE_N*DWIDTH-1:0] data_out,
  output logic                     data_vld,
  output logic                     sol,
  output logic                     eol,
  output logic                     eof,
  output logic                     busy,
  output logic                     frame_done,
  output logic [UF_W-1:0]          underflow_cnt
);

  localparam int BEAT_W = LANE_N * DWIDTH;
  localparam int NFW_W  = (NF_GAP > 0) ? $clog2(NF_GAP + 1) : 1;
  localparam int WAIT_W = (NFW_W > GAP_W) ? NFW_W : GAP_W;

  state_e              state_r, next_state_s;
  logic [CNT_W-1:0]    rows_r, beats_r;
  logic [GAP_W-1:0]    gap_r;
  logic [WAIT_W-1:0]   wait_cnt_r, wait_tgt_s;
  logic                wait_last_s, start_ok_s, empty_s, xfer_s, row_end_s;
  logic                first_beat_s, last_beat_s, last_row_s;
  logic                new_frame_r, busy_r, frame_done_r, data_vld_r, sol_r, eol_r, eof_r;
  logic                new_frame_d_s, busy_d_s, frame_done_d_s, data_vld_d_s, sol_d_s, eol_d_s, eof_d_s;
  logic [BEAT_W-1:0]   data_r, data_d_s;
  logic [UF_W-1:0]     uf_r, uf_d_s;

  assign start_ok_s = (state_r == IDLE) && start;
  assign empty_s    = (rowSize == '0) || (pixPerSlot == '0);
  assign s_rdy      = (state_r == ROW);
  assign xfer_s     = (state_r == ROW) && s_vld && !abort;
  assign row_end_s  = xfer_s && last_beat_s;

  stream_beat_counter #(.CNT_W(CNT_W)) u_cnt (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .clr           (start_ok_s || abort),
    .adv           (xfer_s),
    .row_size      (rows_r),
    .beats_per_row (beats_r),
    .first_beat    (first_beat_s),
    .last_beat     (last_beat_s),
    .last_row      (last_row_s)
  );

  // Configuration is captured only when a start is accepted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rows_r  <= '0;
      beats_r <= '0;
      gap_r   <= '0;
    end else if (start_ok_s) begin
      rows_r  <= rowSize;
      beats_r <= pixPerSlot;
      gap_r   <= rowGap;
    end else begin
      rows_r  <= rows_r;
      beats_r <= beats_r;
      gap_r   <= gap_r;
    end
  end

  // Shared wait timer for the post-frame-pulse pause and the row gaps.
  always_comb begin
    case (state_r)
      NFW:     wait_tgt_s = WAIT_W'(NF_GAP);
      GAP:     wait_tgt_s = WAIT_W'(gap_r);
      default: wait_tgt_s = '0;
    endcase
  end

  assign wait_last_s = (wait_cnt_r == wait_tgt_s - WAIT_W'(1));

  // Wait counter runs only in the timed states and restarts between them.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wait_cnt_r <= '0;
    end else if (((state_r == NFW) || (state_r == GAP)) && !wait_last_s) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = empty_s ? FIN : NFP;
        else       next_state_s = IDLE;
      end
      NFP: begin
        if (abort)              next_state_s = IDLE;
        else if (NF_GAP != 0)   next_state_s = NFW;
        else if (gap_r != '0)   next_state_s = GAP;
        else                    next_state_s = ROW;
      end
      NFW: begin
        if (abort)              next_state_s = IDLE;
        else if (!wait_last_s)  next_state_s = NFW;
        else if (gap_r != '0)   next_state_s = GAP;
        else                    next_state_s = ROW;
      end
      GAP: begin
        if (abort)              next_state_s = IDLE;
        else if (wait_last_s)   next_state_s = ROW;
        else                    next_state_s = GAP;
      end
      ROW: begin
        if (abort)              next_state_s = IDLE;
        else if (!row_end_s)    next_state_s = ROW;
        else if (last_row_s)    next_state_s = FIN;
        else if (gap_r != '0)   next_state_s = GAP;
        else                    next_state_s = ROW;
      end
      FIN:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    new_frame_d_s  = (next_state_s == NFP);
    busy_d_s       = (next_state_s == NFP) || (next_state_s == NFW) ||
                     (next_state_s == GAP) || (next_state_s == ROW);
    frame_done_d_s = (state_r == FIN) && !abort;
    data_vld_d_s   = xfer_s;
    sol_d_s        = xfer_s && first_beat_s;
    eol_d_s        = row_end_s;
    eof_d_s        = row_end_s && last_row_s;
    if (xfer_s) begin
      data_d_s = BEAT_W'(lane_map(MAP_W'(s_data), REVERSE_LANES != 0, LANE_N, DWIDTH));
    end else begin
      data_d_s = data_r;
    end
    if (start_ok_s) begin
      uf_d_s = '0;
    end else if ((state_r == ROW) && !s_vld && (uf_r != {UF_W{1'b1}})) begin
      uf_d_s = uf_r + UF_W'(1);
    end else begin
      uf_d_s = uf_r;
    end
  end

  // Output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      new_frame_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      data_vld_r   <= 1'b0;
      sol_r        <= 1'b0;
      eol_r        <= 1'b0;
      eof_r        <= 1'b0;
      data_r       <= '0;
      uf_r         <= '0;
    end else begin
      new_frame_r  <= new_frame_d_s;
      busy_r       <= busy_d_s;
      frame_done_r <= frame_done_d_s;
      data_vld_r   <= data_vld_d_s;
      sol_r        <= sol_d_s;
      eol_r        <= eol_d_s;
      eof_r        <= eof_d_s;
      data_r       <= data_d_s;
      uf_r         <= uf_d_s;
    end
  end

  assign new_frame     = new_frame_r;
  assign busy          = busy_r;
  assign frame_done    = frame_done_r;
  assign data_vld      = data_vld_r;
  assign sol           = sol_r;
  assign eol           = eol_r;
  assign eof           = eof_r;
  assign data_out      = data_r;
  assign underflow_cnt = uf_r;

endmodule

// File: doc/image_stream_framer.md
Name: image_stream_framer

Overview:
- Synthesizable, parametrised frame source for the image filter pipeline.
- Pulls packed multi-lane pixel beats from an upstream FIFO or memory reader using a valid/ready handshake.
- Re-emits them as a row-structured stream with new_frame, inter-row gaps, line/frame markers and optional lane reversal.
- Sits directly in front of the filter; replaces ad-hoc frame sequencing with a reusable, configurable block that also counts underflow stalls.

Parameters:
- DWIDTH, 10, bits per pixel
- LANE_N, 8, pixels per beat
- CNT_W, 16, width of row/beat counters and size inputs
- GAP_W, 8, width of inter-row gap config
- NF_GAP, 4, idle cycles between the new_frame pulse and the first row gap
- REVERSE_LANES, 1, 1 = input lane k drives output lane LANE_N-1-k; 0 = straight mapping

Ports:
- sys_clk, in, 1, system clock
- sys_rst_n, in, 1, asynchronous active-low reset
- start, in, 1, frame request pulse; sampled only in IDLE
- abort, in, 1, synchronous frame abort
- rowSize, in, CNT_W, rows per frame
- pixPerSlot, in, CNT_W, beats per row
- rowGap, in, GAP_W, idle cycles before each row
- s_data, in, LANE_N*DWIDTH, upstream beat
- s_vld, in, 1, upstream valid
- s_rdy, out, 1, upstream ready
- new_frame, out, 1, one-cycle frame-start pulse to the filter
- data_out, out, LANE_N*DWIDTH, framed beat
- data_vld, out, 1, beat valid
- sol, out, 1, first beat of row (qualified by data_vld)
- eol, out, 1, last beat of row (qualified by data_vld)
- eof, out, 1, last beat of frame (qualified by data_vld)
- busy, out, 1, frame in progress
- frame_done, out, 1, one-cycle completion pulse
- underflow_cnt, out, 16, saturating count of stalled ROW cycles, cleared on each accepted start

Behaviour:
- Reset (sys_rst_n low, asynchronous): state IDLE; all outputs 0, including data_out and underflow_cnt.
- Configuration:
  - rowSize, pixPerSlot and rowGap are latched at an accepted start.
  - Changes while busy have no effect.
- States: IDLE, NFP, NFW, GAP, ROW, FIN.
- IDLE:
  - start=1 at edge T -> NFP.
  - If the latched rowSize==0 or pixPerSlot==0 -> FIN instead; no new_frame, no data.
- NFP:
  - new_frame=1 for exactly this one cycle (T+1).
  - busy=1 from T+1.
  - Next state NFW.
- NFW:
  - Waits NF_GAP cycles (NF_GAP=0 -> zero cycles).
  - Then enters GAP.
- GAP:
  - Waits the latched rowGap cycles (0 -> zero cycles).
  - Then enters ROW.
- ROW:
  - s_rdy=1 combinationally only in ROW.
  - A transfer occurs on s_vld&s_rdy.
  - Each cycle in ROW with s_vld=0 increments underflow_cnt, saturating at 0xFFFF.
  - After pixPerSlot transfers: if more rows remain -> GAP; else -> FIN.
- FIN:
  - frame_done=1 for one cycle.
  - busy=0 in the same cycle.
  - Next state IDLE.
- Output path:
  - Registered with 1-cycle latency: a transfer at cycle C gives data_vld=1 with the mapped beat at C+1.
  - sol/eol/eof are registered alongside the beat.
  - When pixPerSlot==1, sol and eol assert on the same beat.
  - The frame_done cycle immediately follows the eof beat cycle.
  - data_out holds its last value while data_vld=0.
- Counters:
  - Beat counter wraps to 0 at end of row.
  - Row counter increments at end of row.
  - Compares against the latched sizes are exact (no off-by-one).
- abort:
  - Highest priority in any state other than IDLE.
  - Next cycle: state IDLE, s_rdy=0, busy=0, data_vld=0; no frame_done, no eof.
  - A transfer accepted in the abort cycle is discarded.
- Simultaneous events:
  - start while busy is ignored.
  - start and abort together in IDLE: start wins.
- Reset mid-frame: immediate return to reset values.

Decomposition:
- Package image_stream_pkg holds:
  - state enum (IDLE, NFP, NFW, GAP, ROW, FIN);
  - function lane_map(data, reverse) for lane reordering;
  - localparam UF_W=16.
- One sub-module, stream_beat_counter (row/beat counters with wrap and last-flags), instantiated once.
- Expected size: about 200 lines of RTL in total.

Test Plan:
1. rowSize=3, pixPerSlot=4, rowGap=2, s_vld always 1, start at T:
   - new_frame at T+1 only.
   - First data_vld at T+1+NF_GAP+2+2.
   - 12 beats total; eol on beats 4/8/12; eof on beat 12.
   - frame_done the cycle after beat 12; underflow_cnt=0.
2. REVERSE_LANES=1, s_data lanes 0..7 = 0x001..0x008 -> data_out lane 7 = 0x001 and lane 0 = 0x008; REVERSE_LANES=0 -> identity mapping.
3. rowSize=2, pixPerSlot=3, s_vld low for 5 cycles mid-row 1 -> still exactly 6 beats; underflow_cnt=5; s_rdy=0 during GAP/NFW.
4. abort asserted on beat 2 of row 1 -> next cycle busy=0, s_rdy=0, no eof, no frame_done; a following start begins a clean frame with underflow_cnt=0.
5. rowSize=0 -> no new_frame, no data_vld, frame_done one cycle after FIN entry; start asserted during a busy frame is ignored (beat count unchanged).
6. Async reset pulsed low during ROW -> all outputs 0 immediately; after release, frame restarts normally with pixPerSlot=1, where sol=eol on every beat.
